// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32 core (IF, ID, EX, MEM, WB).
// Detects memory-wait, taken-branch, load-use and RAW conditions and drives per-stage
// hold/bubble vectors plus ID-stage operand forwarding selects.
// Optional feature: define PIPE_HAZARD_CTRL_PERF_EN to build the performance counters;
// otherwise cyc_cnt_o, stall_cnt_o and flush_cnt_o are tied to zero.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned FWD_EN      = 1,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_use_i,
  input  logic              id_rs2_use_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              ex_we_i,
  input  logic              mem_we_i,
  input  logic              wb_we_i,
  input  logic              ex_load_i,
  input  logic              mem_op_i,
  input  logic              mem_ready_i,
  input  logic              branch_taken_i,
  output logic [4:0]        hold_o,
  output logic [4:0]        bubble_o,
  output logic [1:0]        fwd_rs1_sel_o,
  output logic [1:0]        fwd_rs2_sel_o,
  output logic              mem_err_o,
  output logic [CNT_W-1:0]  cyc_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam int unsigned WaitW = 16;
  localparam logic [WaitW-1:0] TimeoutVal = WaitW'(MEM_TIMEOUT);

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;

  logic mem_busy, timeout_hit, mem_stall, raw_stall;
  logic haz_ex1, haz_mem1, haz_wb1, haz_ex2, haz_mem2, haz_wb2;

  function automatic logic hazard(input logic              rd_use,
                                  input logic [REG_AW-1:0] rs,
                                  input logic [REG_AW-1:0] rd,
                                  input logic              we);
    return rd_use && we && (rd != '0) && (rd == rs);
  endfunction

  // Youngest producer wins; a load in EX has no result yet, so it cannot forward.
  function automatic logic [1:0] pick_src(input logic h_ex, input logic h_mem,
                                          input logic h_wb, input logic ex_is_load);
    if (h_ex && !ex_is_load) return 2'b01;
    if (h_mem)               return 2'b10;
    if (h_wb)                return 2'b11;
    return 2'b00;
  endfunction

  // Hazard terms and stall qualifiers.
  always_comb begin
    haz_ex1  = hazard(id_rs1_use_i, id_rs1_i, ex_rd_i, ex_we_i);
    haz_mem1 = hazard(id_rs1_use_i, id_rs1_i, mem_rd_i, mem_we_i);
    haz_wb1  = hazard(id_rs1_use_i, id_rs1_i, wb_rd_i, wb_we_i);
    haz_ex2  = hazard(id_rs2_use_i, id_rs2_i, ex_rd_i, ex_we_i);
    haz_mem2 = hazard(id_rs2_use_i, id_rs2_i, mem_rd_i, mem_we_i);
    haz_wb2  = hazard(id_rs2_use_i, id_rs2_i, wb_rd_i, wb_we_i);
    mem_busy    = mem_op_i && !mem_ready_i;
    // A wait that has lasted MEM_TIMEOUT cycles is released for one cycle.
    timeout_hit = (state_q == StMemWait) && (wait_cnt_q >= TimeoutVal);
    mem_stall   = mem_busy && !timeout_hit;
    if (FWD_EN != 0) begin
      raw_stall = ex_load_i && (haz_ex1 || haz_ex2);
    end else begin
      raw_stall = haz_ex1 || haz_mem1 || haz_wb1 || haz_ex2 || haz_mem2 || haz_wb2;
    end
  end

  // Prioritised hold/bubble and forwarding selects.
  always_comb begin
    hold_o        = 5'b00000;
    bubble_o      = 5'b00000;
    fwd_rs1_sel_o = 2'b00;
    fwd_rs2_sel_o = 2'b00;
    if (!rst_n) begin
      bubble_o = 5'b00110;
    end else begin
      if (mem_stall) begin
        hold_o   = 5'b01111;
        bubble_o = 5'b10000;
      end else if (branch_taken_i) begin
        bubble_o = 5'b00110;
      end else if (raw_stall) begin
        hold_o   = 5'b00011;
        bubble_o = 5'b00100;
      end
      if (FWD_EN != 0) begin
        fwd_rs1_sel_o = pick_src(haz_ex1, haz_mem1, haz_wb1, ex_load_i);
        fwd_rs2_sel_o = pick_src(haz_ex2, haz_mem2, haz_wb2, ex_load_i);
      end
    end
  end

  // Memory-wait FSM next state; the counter counts every stalled cycle of one wait.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    unique case (state_q)
      StRun: begin
        if (mem_busy) begin
          state_d    = StMemWait;
          wait_cnt_d = WaitW'(1);
        end else begin
          wait_cnt_d = '0;
        end
      end
      StMemWait: begin
        if (!mem_busy) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else if (timeout_hit) begin
          state_d    = StRun;
          wait_cnt_d = '0;
          mem_err_d  = 1'b1;
        end else if (wait_cnt_q < TimeoutVal) begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = '0;
      end
    endcase
  end

  // FSM, wait counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_err_o = mem_err_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic             branch_flush;
  logic [CNT_W-1:0] cyc_q, stall_q, flush_q;

  assign branch_flush = rst_n && !mem_stall && branch_taken_i;

  // Free-running performance counters, wrapping at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      cyc_q <= cyc_q + CNT_W'(1);
      if (hold_o[0])    stall_q <= stall_q + CNT_W'(1);
      if (branch_flush) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign cyc_cnt_o   = cyc_q;
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;
`else
  assign cyc_cnt_o   = '0;
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: two instances (forwarding with MEM_TIMEOUT=4,
// stall-only with MEM_TIMEOUT=3) share stimulus; a reference model pushes expectations.
module tb_pipe_hazard_ctrl;
  localparam int CW = 32;
  localparam int T0 = 4;
  localparam int T1 = 3;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  localparam bit PerfOn = 1'b1;
`else
  localparam bit PerfOn = 1'b0;
`endif

  typedef struct {
    logic [4:0]    hold;
    logic [4:0]    bubble;
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic          err;
    logic [CW-1:0] cyc;
    logic [CW-1:0] stl;
    logic [CW-1:0] fl;
    bit            live;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic rs1_use, rs2_use, ex_we, mem_we, wb_we, ex_load, mem_op, mem_ready, br;

  logic [4:0]    hold   [2];
  logic [4:0]    bubble [2];
  logic [1:0]    s1     [2];
  logic [1:0]    s2     [2];
  logic          err    [2];
  logic [CW-1:0] cyc    [2];
  logic [CW-1:0] stl    [2];
  logic [CW-1:0] fl     [2];

  exp_t sb0[$];
  exp_t sb1[$];

  int            waited [2];
  bit            err_m  [2];
  logic [CW-1:0] cyc_m  [2];
  logic [CW-1:0] stl_m  [2];
  logic [CW-1:0] fl_m   [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .MEM_TIMEOUT(T0), .CNT_W(CW)) u_fwd (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rs1_use_i(rs1_use), .id_rs2_use_i(rs2_use),
    .ex_rd_i(ex_rd), .mem_rd_i(mem_rd), .wb_rd_i(wb_rd),
    .ex_we_i(ex_we), .mem_we_i(mem_we), .wb_we_i(wb_we), .ex_load_i(ex_load),
    .mem_op_i(mem_op), .mem_ready_i(mem_ready), .branch_taken_i(br),
    .hold_o(hold[0]), .bubble_o(bubble[0]), .fwd_rs1_sel_o(s1[0]), .fwd_rs2_sel_o(s2[0]),
    .mem_err_o(err[0]), .cyc_cnt_o(cyc[0]), .stall_cnt_o(stl[0]), .flush_cnt_o(fl[0])
  );

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .MEM_TIMEOUT(T1), .CNT_W(CW)) u_stall (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rs1_use_i(rs1_use), .id_rs2_use_i(rs2_use),
    .ex_rd_i(ex_rd), .mem_rd_i(mem_rd), .wb_rd_i(wb_rd),
    .ex_we_i(ex_we), .mem_we_i(mem_we), .wb_we_i(wb_we), .ex_load_i(ex_load),
    .mem_op_i(mem_op), .mem_ready_i(mem_ready), .branch_taken_i(br),
    .hold_o(hold[1]), .bubble_o(bubble[1]), .fwd_rs1_sel_o(s1[1]), .fwd_rs2_sel_o(s2[1]),
    .mem_err_o(err[1]), .cyc_cnt_o(cyc[1]), .stall_cnt_o(stl[1]), .flush_cnt_o(fl[1])
  );

  // Reference: which producers each operand depends on, then the priority rules.
  function automatic exp_t model(input int k);
    exp_t       e;
    logic [4:0] prd [3];
    logic       pwe [3];
    logic [4:0] rs  [2];
    logic       used[2];
    bit         hit [2][3];
    logic [1:0] sel [2];
    bit         any_hit, load_use, fwd, mem_wait;
    int         tmo;
    prd[0] = ex_rd;  prd[1] = mem_rd;  prd[2] = wb_rd;
    pwe[0] = ex_we;  pwe[1] = mem_we;  pwe[2] = wb_we;
    rs[0]  = id_rs1; rs[1]  = id_rs2;
    used[0] = rs1_use; used[1] = rs2_use;
    fwd = (k == 0);
    tmo = (k == 0) ? T0 : T1;
    any_hit = 1'b0;
    for (int o = 0; o < 2; o++) begin
      for (int s = 0; s < 3; s++) begin
        hit[o][s] = used[o] && pwe[s] && (prd[s] != 0) && (prd[s] == rs[o]);
        any_hit   = any_hit || hit[o][s];
      end
    end
    load_use = ex_load && (hit[0][0] || hit[1][0]);
    for (int o = 0; o < 2; o++) begin
      sel[o] = 2'b00;
      if (fwd) begin
        // Oldest first, so the youngest usable producer is the one left standing.
        for (int s = 2; s >= 0; s--) begin
          if (hit[o][s] && !(s == 0 && ex_load)) sel[o] = 2'(s + 1);
        end
      end
    end
    mem_wait = mem_op && !mem_ready && (waited[k] < tmo);
    e.hold = 5'b0; e.bubble = 5'b0; e.s1 = sel[0]; e.s2 = sel[1];
    if (!rst_n) begin
      e.bubble = 5'b00110; e.s1 = 2'b00; e.s2 = 2'b00;
    end else if (mem_wait) begin
      e.hold = 5'b01111; e.bubble = 5'b10000;
    end else if (br) begin
      e.bubble = 5'b00110;
    end else if (fwd ? load_use : any_hit) begin
      e.hold = 5'b00011; e.bubble = 5'b00100;
    end
    e.live = rst_n;
    e.err  = err_m[k];
    e.cyc  = PerfOn ? cyc_m[k] : '0;
    e.stl  = PerfOn ? stl_m[k] : '0;
    e.fl   = PerfOn ? fl_m[k]  : '0;
    return e;
  endfunction

  // State the reference carries across the clock edge ending this cycle.
  function automatic void advance(input int k, input exp_t e);
    int tmo;
    tmo = (k == 0) ? T0 : T1;
    if (!rst_n) begin
      waited[k] = 0; err_m[k] = 1'b0;
      cyc_m[k] = '0; stl_m[k] = '0; fl_m[k] = '0;
    end else begin
      if (mem_op && !mem_ready) begin
        if (waited[k] < tmo) waited[k]++;
        else begin
          waited[k] = 0; err_m[k] = 1'b1;
        end
      end else begin
        waited[k] = 0;
      end
      cyc_m[k] = cyc_m[k] + 1;
      if (e.hold[0]) stl_m[k] = stl_m[k] + 1;
      if (e.hold == 5'b0 && e.bubble == 5'b00110) fl_m[k] = fl_m[k] + 1;
    end
  endfunction

  task automatic check(input string nm, input int k, input logic [CW-1:0] got,
                       input logic [CW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", nm, k, $time, got, want);
    end
  endtask

  task automatic compare(input int k, input exp_t e);
    check("hold", k, CW'(hold[k]), CW'(e.hold));
    check("bubble", k, CW'(bubble[k]), CW'(e.bubble));
    check("fwd_rs1", k, CW'(s1[k]), CW'(e.s1));
    check("fwd_rs2", k, CW'(s2[k]), CW'(e.s2));
    if (e.live) begin
      check("mem_err", k, CW'(err[k]), CW'(e.err));
      check("cyc_cnt", k, cyc[k], e.cyc);
      check("stall_cnt", k, stl[k], e.stl);
      check("flush_cnt", k, fl[k], e.fl);
    end
  endtask

  // Monitor: outputs are combinational, so one expectation is due every driven cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb0.size() > 0) begin
      e = sb0.pop_front();
      compare(0, e);
    end
    if (sb1.size() > 0) begin
      e = sb1.pop_front();
      compare(1, e);
    end
  end

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    rst_n = 1'b1; id_rs1 = '0; id_rs2 = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
    rs1_use = 1'b0; rs2_use = 1'b0; ex_we = 1'b0; mem_we = 1'b0; wb_we = 1'b0;
    ex_load = 1'b0; mem_op = 1'b0; mem_ready = 1'b1; br = 1'b0;
  endtask

  task automatic end_cycle();
    exp_t e0, e1;
    e0 = model(0);
    e1 = model(1);
    sb0.push_back(e0);
    sb1.push_back(e1);
    advance(0, e0);
    advance(1, e1);
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      begin_cycle(); rst_n = 1'b0; end_cycle();
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      begin_cycle(); end_cycle();
    end
  endtask

  task automatic load_use_cycle();
    begin_cycle();
    ex_load = 1'b1; ex_we = 1'b1; ex_rd = 5'd7; rs2_use = 1'b1; id_rs2 = 5'd7;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      waited[k] = 0; err_m[k] = 1'b0; cyc_m[k] = '0; stl_m[k] = '0; fl_m[k] = '0;
    end
    rst_n = 1'b0;
    reset_cycles(3);

    // ADD x5 in EX, ID reads x5.
    begin_cycle(); ex_we = 1'b1; ex_rd = 5'd5; rs1_use = 1'b1; id_rs1 = 5'd5; end_cycle();

    // LW x7 in EX, ID reads x7; next cycle the load sits in MEM.
    load_use_cycle(); end_cycle();
    begin_cycle(); mem_we = 1'b1; mem_rd = 5'd7; rs2_use = 1'b1; id_rs2 = 5'd7; end_cycle();

    // Same load-use with a taken branch: branch wins.
    load_use_cycle(); br = 1'b1; end_cycle();

    // RAM not ready for 3 cycles, then ready.
    for (int i = 0; i < 3; i++) begin
      begin_cycle(); mem_op = 1'b1; mem_ready = 1'b0; br = 1'b1; end_cycle();
    end
    begin_cycle(); mem_op = 1'b1; end_cycle();

    // Ready held low past the timeout, then error stays sticky.
    for (int i = 0; i < 7; i++) begin
      begin_cycle(); mem_op = 1'b1; mem_ready = 1'b0; end_cycle();
    end
    idle_cycles(3);

    // Writer x3 advancing EX -> MEM -> WB while ID reads x3.
    begin_cycle(); ex_we = 1'b1; ex_rd = 5'd3; rs1_use = 1'b1; id_rs1 = 5'd3; end_cycle();
    begin_cycle(); mem_we = 1'b1; mem_rd = 5'd3; rs1_use = 1'b1; id_rs1 = 5'd3; end_cycle();
    begin_cycle(); wb_we = 1'b1; wb_rd = 5'd3; rs1_use = 1'b1; id_rs1 = 5'd3; end_cycle();
    begin_cycle(); rs1_use = 1'b1; id_rs1 = 5'd3; end_cycle();

    // x0 writers never stall or forward.
    begin_cycle();
    ex_we = 1'b1; mem_we = 1'b1; wb_we = 1'b1; rs1_use = 1'b1; rs2_use = 1'b1;
    end_cycle();

    // Reset in the middle of a wait.
    for (int i = 0; i < 2; i++) begin
      begin_cycle(); mem_op = 1'b1; mem_ready = 1'b0; end_cycle();
    end
    reset_cycles(1);
    begin_cycle(); mem_op = 1'b1; mem_ready = 1'b0; end_cycle();

    // Ten cycles after reset with two stalls and one branch, then observe the counters.
    reset_cycles(2);
    load_use_cycle(); end_cycle();
    idle_cycles(2);
    load_use_cycle(); end_cycle();
    begin_cycle(); br = 1'b1; end_cycle();
    idle_cycles(6);

    // Randomised traffic over a small register set to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      begin_cycle();
      rst_n     = ($urandom_range(0, 99) != 0);
      id_rs1    = 5'($urandom_range(0, 3));
      id_rs2    = 5'($urandom_range(0, 3));
      ex_rd     = 5'($urandom_range(0, 3));
      mem_rd    = 5'($urandom_range(0, 3));
      wb_rd     = 5'($urandom_range(0, 3));
      rs1_use   = ($urandom_range(0, 9) < 7);
      rs2_use   = ($urandom_range(0, 9) < 7);
      ex_we     = ($urandom_range(0, 9) < 7);
      mem_we    = ($urandom_range(0, 9) < 7);
      wb_we     = ($urandom_range(0, 9) < 7);
      ex_load   = ($urandom_range(0, 9) < 3);
      br        = ($urandom_range(0, 9) == 0);
      mem_op    = ($urandom_range(0, 9) < 4);
      mem_ready = ($urandom_range(0, 9) < 4);
      end_cycle();
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    check("sb_drain", 0, CW'(sb0.size() + sb1.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
